// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the real-time
// pixel fetcher (high priority) and the CPU bus port. The issue stage drives
// registered memory strobes; a two-stage tag pipeline routes read data back
// to whichever requester issued the read. A starvation counter forces the CPU
// ahead of the pixel fetcher after STARVE_LIMIT consecutive denied cycles.
//
// Handshake: a requester holds req (and its address/data) stable until it
// sees gnt; a transfer happens in exactly the cycle where req && gnt are both
// high. Grants are combinational from this cycle's requests and registered
// state, and at most one transfer is accepted per cycle.
module vram_arbiter #(
   parameter int ADDR_W       = 19,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              px_req,
   input  logic [ADDR_W-1:0] px_addr,
   output logic              px_gnt,
   output logic [7:0]        px_rdata,
   output logic              px_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_gnt,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   // Read-return tags: which requester (if any) owns the read in each stage.
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_PX   = 2'd1;
   localparam logic [1:0] TAG_CPU  = 2'd2;

   logic [CNT_W-1:0] starve_cnt;
   logic             cpu_busy;
   logic [1:0]       tag_s1;   // aligned with mem_en / mem_addr
   logic [1:0]       tag_s2;   // aligned with mem_rdata
   logic             force_cpu;
   logic             px_xfer;
   logic             cpu_xfer;

   // Grant logic: pixel fetcher wins ties unless the CPU has starved long enough.
   always_comb begin
      force_cpu = (starve_cnt == CNT_W'(STARVE_LIMIT));
      cpu_gnt   = !reset && cpu_req && !cpu_busy && (force_cpu || !px_req);
      px_gnt    = !reset && px_req && !(force_cpu && cpu_req && !cpu_busy);
      px_xfer   = px_req && px_gnt;
      cpu_xfer  = cpu_req && cpu_gnt;
   end

   // Issue stage: register the winning access onto the VRAM port.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         tag_s1    <= TAG_NONE;
      end else begin
         mem_en <= px_xfer || cpu_xfer;
         mem_we <= cpu_xfer && cpu_we;
         if (px_xfer) begin
            mem_addr <= px_addr;
         end else if (cpu_xfer) begin
            mem_addr <= cpu_addr;
            if (cpu_we) begin
               mem_wdata <= cpu_wdata;
            end
         end
         if (px_xfer) begin
            tag_s1 <= TAG_PX;
         end else if (cpu_xfer && !cpu_we) begin
            tag_s1 <= TAG_CPU;
         end else begin
            tag_s1 <= TAG_NONE;
         end
      end
   end

   // Return stage: steer mem_rdata to the owning requester; the other data output holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_s2    <= TAG_NONE;
         px_rdata  <= '0;
         px_valid  <= 1'b0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
      end else begin
         tag_s2   <= tag_s1;
         px_valid <= (tag_s2 == TAG_PX);
         if (tag_s2 == TAG_PX) begin
            px_rdata <= mem_rdata;
         end
         // Writes acknowledge one cycle after the handshake; reads when data lands.
         cpu_ack <= (cpu_xfer && cpu_we) || (tag_s2 == TAG_CPU);
         if (tag_s2 == TAG_CPU) begin
            cpu_rdata <= mem_rdata;
         end
      end
   end

   // CPU read-outstanding flag: set on read issue, cleared as its ack is registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_busy <= 1'b0;
      end else if (tag_s2 == TAG_CPU) begin
         cpu_busy <= 1'b0;
      end else if (cpu_xfer && !cpu_we) begin
         cpu_busy <= 1'b1;
      end
   end

   // Starvation counter: counts denied CPU cycles, saturating at the force threshold.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!cpu_req || cpu_xfer) begin
         starve_cnt <= '0;
      end else if (!cpu_busy && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table of single-cycle grant vectors plus hand-written
// multi-cycle sequences, with a scoreboard that predicts every px_valid /
// cpu_ack (cycle and data) at handshake time from a shadow memory.
module tb_vram_arbiter;

   localparam int ADDR_W = 19;
   localparam int STARVE_LIMIT = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              px_req = 1'b0;
   logic [ADDR_W-1:0] px_addr = '0;
   logic              px_gnt;
   logic [7:0]        px_rdata;
   logic              px_valid;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [7:0]        cpu_wdata = '0;
   logic              cpu_gnt;
   logic [7:0]        cpu_rdata;
   logic              cpu_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata = '0;

   vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .px_req(px_req), .px_addr(px_addr), .px_gnt(px_gnt),
      .px_rdata(px_rdata), .px_valid(px_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- VRAM model: unwritten bytes read back as addr[7:0] ----------------
   logic [7:0] ram [logic [ADDR_W-1:0]];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : mem_addr[7:0];
      end
   end

   // ---------------- check bookkeeping ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [7:0]  shadow [logic [ADDR_W-1:0]];
   logic [7:0]  px_exp_q[$];
   int          px_due_q[$];
   logic [7:0]  cpu_exp_q[$];
   int          cpu_due_q[$];
   logic        cpu_wr_q[$];
   logic [7:0]  last_px = '0;
   logic [7:0]  last_cpu = '0;

   function automatic logic [7:0] shadow_rd(input logic [ADDR_W-1:0] a);
      return shadow.exists(a) ? shadow[a] : a[7:0];
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         chk("reset_px_gnt", {31'd0, px_gnt}, 32'd0);
         chk("reset_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
         px_exp_q.delete(); px_due_q.delete();
         cpu_exp_q.delete(); cpu_due_q.delete(); cpu_wr_q.delete();
         last_px = '0;
         last_cpu = '0;
      end else begin
         // pixel return path
         if (px_valid) begin
            if (px_exp_q.size() == 0) begin
               chk("px_valid_unexpected", 32'd1, 32'd0);
            end else begin
               chk("px_valid_cycle", px_due_q[0], cyc);
               chk("px_rdata", {24'd0, px_rdata}, {24'd0, px_exp_q[0]});
               last_px = px_exp_q[0];
               void'(px_exp_q.pop_front()); void'(px_due_q.pop_front());
            end
         end else begin
            if (px_due_q.size() != 0 && px_due_q[0] <= cyc) begin
               chk("px_valid_missing", 32'd0, 32'd1);
               void'(px_exp_q.pop_front()); void'(px_due_q.pop_front());
            end
            chk("px_rdata_hold", {24'd0, px_rdata}, {24'd0, last_px});
         end
         // cpu return path
         if (cpu_ack) begin
            if (cpu_exp_q.size() == 0) begin
               chk("cpu_ack_unexpected", 32'd1, 32'd0);
            end else begin
               chk("cpu_ack_cycle", cpu_due_q[0], cyc);
               if (!cpu_wr_q[0]) last_cpu = cpu_exp_q[0];
               chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, last_cpu});
               void'(cpu_exp_q.pop_front()); void'(cpu_due_q.pop_front());
               void'(cpu_wr_q.pop_front());
            end
         end else begin
            if (cpu_due_q.size() != 0 && cpu_due_q[0] <= cyc) begin
               chk("cpu_ack_missing", 32'd0, 32'd1);
               void'(cpu_exp_q.pop_front()); void'(cpu_due_q.pop_front());
               void'(cpu_wr_q.pop_front());
            end
            chk("cpu_rdata_hold", {24'd0, cpu_rdata}, {24'd0, last_cpu});
         end
         // record handshakes of this cycle
         if (px_req && px_gnt && cpu_req && cpu_gnt) chk("two_grants", 32'd1, 32'd0);
         if (px_req && px_gnt) begin
            px_exp_q.push_back(shadow_rd(px_addr));
            px_due_q.push_back(cyc + 3);
         end
         if (cpu_req && cpu_gnt) begin
            if (cpu_we) begin
               shadow[cpu_addr] = cpu_wdata;
               cpu_exp_q.push_back(cpu_wdata);
               cpu_due_q.push_back(cyc + 1);
               cpu_wr_q.push_back(1'b1);
            end else begin
               cpu_exp_q.push_back(shadow_rd(cpu_addr));
               cpu_due_q.push_back(cyc + 3);
               cpu_wr_q.push_back(1'b0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      px_req = 1'b0;
      cpu_req = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Hold px_req and cpu_req together; advance px_addr on each pixel grant and
   // drop cpu_req once granted. Reports pixel grants seen before the CPU grant.
   task automatic contend(input logic [ADDR_W-1:0] px_base, input logic we,
                          input logic [ADDR_W-1:0] c_addr, input logic [7:0] c_data,
                          output int npx, output int cpu_at);
      logic g_px;
      logic done;
      npx = 0;
      cpu_at = -1;
      done = 1'b0;
      px_req = 1'b1; px_addr = px_base;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = c_addr; cpu_wdata = c_data;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         g_px = px_gnt;
         if (cpu_gnt) begin
            cpu_at = k;
            done = 1'b1;
            chk("force_px_gnt_low", {31'd0, px_gnt}, 32'd0);
         end else if (g_px) begin
            npx++;
         end
         tick();
         if (g_px) px_addr = px_addr + 1'b1;
         if (done) cpu_req = 1'b0;
      end
      if (!done) chk("cpu_grant_timeout", 32'd0, 32'd1);
      // CPU dropped: pixel fetcher gets the next slot, counter cleared
      @(negedge clk);
      chk("px_resume", {31'd0, px_gnt}, 32'd1);
      tick();
      px_req = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic px_req;
      logic cpu_req;
      logic cpu_we;
      logic exp_px_gnt;
      logic exp_cpu_gnt;
      logic exp_mem_en;
      logic exp_mem_we;
   } vec_t;

   vec_t vecs[6];

   int npx;
   int cpu_at;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // power-on reset
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
      chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      tick();

      // single-cycle grant vectors from an idle state
      for (int i = 0; i < 6; i++) begin
         px_req = vecs[i].px_req;
         px_addr = ADDR_W'(32'h200 + i);
         cpu_req = vecs[i].cpu_req;
         cpu_we = vecs[i].cpu_we;
         cpu_addr = ADDR_W'(32'h4000 + i);
         cpu_wdata = 8'hA0 + 8'(i);
         @(negedge clk);
         chk("vec_px_gnt", {31'd0, px_gnt}, {31'd0, vecs[i].exp_px_gnt});
         chk("vec_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, vecs[i].exp_cpu_gnt});
         tick();
         px_req = 1'b0;
         cpu_req = 1'b0;
         @(negedge clk);
         chk("vec_mem_en", {31'd0, mem_en}, {31'd0, vecs[i].exp_mem_en});
         chk("vec_mem_we", {31'd0, mem_we}, {31'd0, vecs[i].exp_mem_we});
         if (vecs[i].exp_mem_en)
            chk("vec_mem_addr", 32'(mem_addr),
                vecs[i].px_req ? 32'h200 + i : 32'h4000 + i);
         idle(4);
      end

      // pixel streaming, addresses 0..9, continuous mem_en
      for (int i = 0; i < 10; i++) begin
         px_req = 1'b1;
         px_addr = ADDR_W'(i);
         @(negedge clk);
         chk("stream_px_gnt", {31'd0, px_gnt}, 32'd1);
         if (i > 0) chk("stream_mem_en", {31'd0, mem_en}, 32'd1);
         tick();
      end
      px_req = 1'b0;
      @(negedge clk);
      chk("stream_mem_en_last", {31'd0, mem_en}, 32'd1);
      idle(5);

      // CPU write 0x5A to 0x1234 then read it back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h1234; cpu_wdata = 8'h5A;
      @(negedge clk);
      chk("wr_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      tick();
      cpu_we = 1'b0;
      @(negedge clk);
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
      chk("wr_cpu_ack", {31'd0, cpu_ack}, 32'd1);
      chk("rd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      tick();
      @(negedge clk);
      chk("rd_busy_gnt1", {31'd0, cpu_gnt}, 32'd0);
      tick();
      @(negedge clk);
      chk("rd_busy_gnt2", {31'd0, cpu_gnt}, 32'd0);
      tick();
      @(negedge clk);
      chk("rd_ack_at_3", {31'd0, cpu_ack}, 32'd1);
      chk("rd_next_gnt", {31'd0, cpu_gnt}, 32'd1);
      tick();
      idle(5);

      // contention with a CPU write: 8 pixel grants then the CPU
      contend(19'h60, 1'b1, 19'h100, 8'hC3, npx, cpu_at);
      chk("starve_px_grants", npx, STARVE_LIMIT);
      chk("starve_cpu_cycle", cpu_at, STARVE_LIMIT);
      idle(5);

      // idle slot: nothing issued, nothing returned
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
         chk("idle_px_valid", {31'd0, px_valid}, 32'd0);
         chk("idle_cpu_ack", {31'd0, cpu_ack}, 32'd0);
         tick();
      end

      // mixed returns: px read, forced CPU read, px read on consecutive cycles
      contend(19'h20, 1'b0, 19'h1234, 8'h00, npx, cpu_at);
      chk("mixed_px_grants", npx, STARVE_LIMIT);
      chk("mixed_cpu_cycle", cpu_at, STARVE_LIMIT);
      idle(6);

      // reset mid-stream with two pixel reads in flight
      px_req = 1'b1; px_addr = 19'h40;
      tick();
      px_addr = 19'h41;
      tick();
      px_req = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("post_rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("post_rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("post_rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("post_rst_px_valid", {31'd0, px_valid}, 32'd0);
      chk("post_rst_px_rdata", {24'd0, px_rdata}, 32'd0);
      chk("post_rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      chk("post_rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
      idle(5);

      if (px_exp_q.size() != 0 || cpu_exp_q.size() != 0)
         chk("scoreboard_drained", px_exp_q.size() + cpu_exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
